// File: rtl/mem_bus_arbiter_if.sv
// Shared-memory arbitration bundle: two requesting masters plus the single
// memory bus they contend for. The arbiter uses the slave view. Whatever
// drives the requests and returns device read data uses the master view.
interface mem_bus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Device_Read_Data;

  logic        bus_owner;
  logic        bus_busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  Device_Read_Data,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output MemBus_Address, MemBus_Write_Data, MemRead, MemWrite,
    output bus_owner, bus_busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output Device_Read_Data,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  MemBus_Address, MemBus_Write_Data, MemRead, MemWrite,
    input  bus_owner, bus_busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter. Each beat is one ACCESS cycle followed by
// one GAP cycle, so a master has time to update its request after its ack.
// Ownership is round-robin from idle. While the other master is waiting, the
// current owner is limited to MAX_BURST consecutive beats.
module mem_bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               reset,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_t      r_state;
  logic        r_owner;
  logic        r_lastOwner;
  logic [3:0]  r_beatCnt;

  logic        w_reqOwner;
  logic        w_reqOther;
  logic        w_budgetLeft;
  logic        w_idleGrant;
  logic        w_weOwner;

  assign w_reqOwner   = r_owner ? bus.m1_req : bus.m0_req;
  assign w_reqOther   = r_owner ? bus.m0_req : bus.m1_req;
  assign w_budgetLeft = (r_beatCnt < BURST_LIMIT);
  assign w_idleGrant  = (bus.m0_req && bus.m1_req) ? ~r_lastOwner : bus.m1_req;
  assign w_weOwner    = r_owner ? bus.m1_we : bus.m0_we;

  // State, ownership and burst accounting; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_lastOwner <= 1'b1;
      r_beatCnt   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            r_state <= ACCESS;
            r_owner <= w_idleGrant;
            if (w_idleGrant != r_owner) begin
              r_lastOwner <= r_owner;
            end
            r_beatCnt <= 4'd0;
          end
        end
        ACCESS: begin
          r_state <= GAP;
          if (r_beatCnt != 4'hF) begin
            r_beatCnt <= r_beatCnt + 4'd1;
          end
        end
        GAP: begin
          if (w_reqOwner && (!w_reqOther || w_budgetLeft)) begin
            r_state <= ACCESS;
            if (!w_budgetLeft) begin
              r_beatCnt <= 4'd0;
            end
          end else if (w_reqOther) begin
            r_state     <= ACCESS;
            r_owner     <= ~r_owner;
            r_lastOwner <= r_owner;
            r_beatCnt   <= 4'd0;
          end else begin
            r_state     <= IDLE;
            r_lastOwner <= r_owner;
            r_beatCnt   <= 4'd0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Bus strobes, acks and read data are decoded purely from state and owner.
  always_comb begin
    bus.m0_ack            = 1'b0;
    bus.m0_rdata          = 32'h0;
    bus.m1_ack            = 1'b0;
    bus.m1_rdata          = 32'h0;
    bus.MemBus_Address    = 32'h0;
    bus.MemBus_Write_Data = 32'h0;
    bus.MemRead           = 1'b0;
    bus.MemWrite          = 1'b0;
    if (r_state == ACCESS) begin
      bus.MemBus_Address    = r_owner ? bus.m1_addr  : bus.m0_addr;
      bus.MemBus_Write_Data = r_owner ? bus.m1_wdata : bus.m0_wdata;
      bus.MemRead           = ~w_weOwner;
      bus.MemWrite          = w_weOwner;
      if (r_owner) begin
        bus.m1_ack   = 1'b1;
        bus.m1_rdata = bus.Device_Read_Data;
      end else begin
        bus.m0_ack   = 1'b1;
        bus.m0_rdata = bus.Device_Read_Data;
      end
    end
  end

  assign bus.bus_owner = r_owner;
  assign bus.bus_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. It runs a vector table covering
// reset, single beats and mid-beat reset. Hand sequences cover fairness and
// lone-master streaming. Random traffic is compared against a beat-level model.
module tb_mem_bus_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Beat-level reference: is this cycle a bus beat, is a transfer in flight,
  // who holds the bus, who held it before, and the length of the current run.
  logic mBeat;
  logic mBusy;
  int   mOwner;
  int   mLast;
  int   mRun;

  typedef struct {
    logic         rst;
    logic         r0;
    logic         we0;
    logic [31:0]  a0;
    logic [31:0]  d0;
    logic         r1;
    logic         we1;
    logic [31:0]  a1;
    logic [31:0]  d1;
    logic [31:0]  dev;
    logic [133:0] exp;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [133:0] packOut(logic a0, logic [31:0] d0, logic a1, logic [31:0] d1,
                                           logic [31:0] ad, logic [31:0] wd, logic rd, logic wr,
                                           logic own, logic bsy);
    return {a0, d0, a1, d1, ad, wd, rd, wr, own, bsy};
  endfunction

  function automatic logic [133:0] dutOut();
    return {bus.m0_ack, bus.m0_rdata, bus.m1_ack, bus.m1_rdata, bus.MemBus_Address,
            bus.MemBus_Write_Data, bus.MemRead, bus.MemWrite, bus.bus_owner, bus.bus_busy};
  endfunction

  function automatic logic [133:0] expIdle(logic own, logic bsy);
    return packOut(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, own, bsy);
  endfunction

  function automatic logic [133:0] expBeat(logic own, logic we, logic [31:0] ad,
                                           logic [31:0] wd, logic [31:0] rdata);
    if (own) return packOut(1'b0, 32'h0, 1'b1, rdata, ad, wd, ~we, we, 1'b1, 1'b1);
    return packOut(1'b1, rdata, 1'b0, 32'h0, ad, wd, ~we, we, 1'b0, 1'b1);
  endfunction

  function automatic logic [133:0] modelOut();
    logic own;
    own = 1'(mOwner);
    if (mBeat) begin
      if (own) return expBeat(1'b1, bus.m1_we, bus.m1_addr, bus.m1_wdata, bus.Device_Read_Data);
      return expBeat(1'b0, bus.m0_we, bus.m0_addr, bus.m0_wdata, bus.Device_Read_Data);
    end
    return expIdle(own, mBusy);
  endfunction

  // Advance the reference by one clock, using the inputs present at the edge.
  task automatic modelStep();
    logic r0, r1, mine, other;
    int who;
    r0 = bus.m0_req;
    r1 = bus.m1_req;
    if (!reset) begin
      mBeat = 1'b0; mBusy = 1'b0; mOwner = 0; mLast = 1; mRun = 0;
    end else if (mBeat) begin
      mBeat = 1'b0;
      mRun  = (mRun < 15) ? mRun + 1 : 15;
    end else begin
      who = -1;
      if (!mBusy) begin
        if (r0 && r1) who = 1 - mLast;
        else if (r0)  who = 0;
        else if (r1)  who = 1;
      end else begin
        mine  = (mOwner == 1) ? r1 : r0;
        other = (mOwner == 1) ? r0 : r1;
        if (mine && (!other || mRun < MAXB)) who = mOwner;
        else if (other)                      who = 1 - mOwner;
      end
      if (who < 0) begin
        if (mBusy) mLast = mOwner;
        mBusy = 1'b0;
        mRun  = 0;
      end else begin
        if (who != mOwner) begin
          mLast = mOwner;
          mRun  = 0;
        end else if (mRun >= MAXB) begin
          mRun = 0;
        end
        mOwner = who;
        mBeat  = 1'b1;
        mBusy  = 1'b1;
      end
    end
  endtask

  task automatic clockCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(logic rst, logic r0, logic we0, logic [31:0] a0, logic [31:0] d0,
                               logic r1, logic we1, logic [31:0] a1, logic [31:0] d1,
                               logic [31:0] dev);
    reset                = rst;
    bus.m0_req           = r0;
    bus.m0_we            = we0;
    bus.m0_addr          = a0;
    bus.m0_wdata         = d0;
    bus.m1_req           = r1;
    bus.m1_we            = we1;
    bus.m1_addr          = a1;
    bus.m1_wdata         = d1;
    bus.Device_Read_Data = dev;
  endtask

  task automatic compare(string name, logic [133:0] act, logic [133:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string name, logic [133:0] exp);
    compare(name, dutOut(), exp);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 32'h0,  32'h0,  32'h0,
                expIdle(1'b0, 1'b0)};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 32'h0,  32'h0,  32'h0,
                expIdle(1'b0, 1'b0)};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0,    1'b0, 1'b0, 32'h0,  32'h0,  32'hDEADBEEF,
                expBeat(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF)};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,    1'b0, 1'b0, 32'h0,  32'h0,  32'hDEADBEEF,
                expIdle(1'b0, 1'b1)};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,    1'b0, 1'b0, 32'h0,  32'h0,  32'hDEADBEEF,
                expIdle(1'b0, 1'b0)};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h20, 32'hA5A5, 1'b1, 1'b1, 32'h30, 32'h55, 32'h1234,
                expIdle(1'b0, 1'b0)};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h20, 32'hA5A5, 1'b1, 1'b1, 32'h30, 32'h55, 32'h1234,
                expBeat(1'b0, 1'b0, 32'h20, 32'hA5A5, 32'h1234)};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h20, 32'hA5A5, 1'b1, 1'b1, 32'h30, 32'h55, 32'h1234,
                expIdle(1'b0, 1'b1)};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h20, 32'hA5A5, 1'b1, 1'b1, 32'h30, 32'h55, 32'h1234,
                expBeat(1'b1, 1'b1, 32'h30, 32'h55, 32'h1234)};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h20, 32'hA5A5, 1'b0, 1'b1, 32'h30, 32'h55, 32'h1234,
                expIdle(1'b1, 1'b1)};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h20, 32'hA5A5, 1'b0, 1'b1, 32'h30, 32'h55, 32'h1234,
                expIdle(1'b1, 1'b0)};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h40, 32'h77,   1'b0, 1'b0, 32'h0,  32'h0,  32'h99,
                expBeat(1'b0, 1'b1, 32'h40, 32'h77, 32'h99)};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h77,   1'b1, 1'b1, 32'h50, 32'h66, 32'h99,
                expIdle(1'b0, 1'b0)};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h77,   1'b1, 1'b1, 32'h50, 32'h66, 32'h99,
                expBeat(1'b0, 1'b0, 32'h40, 32'h77, 32'h99)};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].r0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
                    tbl[i].r1, tbl[i].we1, tbl[i].a1, tbl[i].d1, tbl[i].dev);
      clockCycle();
      checkOutput($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Fairness: both masters hold requests. Beats alternate owner every MAXB beats.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    clockCycle();
    clockCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 32'hCAFE);
    for (int k = 1; k <= 17; k++) begin
      logic [1:0] expAck;
      int beat;
      clockCycle();
      expAck = 2'b00;
      if (k % 2 == 1) begin
        beat   = (k - 1) / 2;
        expAck = (((beat / MAXB) % 2) == 0) ? 2'b10 : 2'b01;
      end
      compare($sformatf("fair cycle%0d acks", k), 134'({bus.m0_ack, bus.m1_ack}), 134'(expAck));
    end

    // Lone master 1 streams ten writes with no idle cycles in between.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    clockCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h1000, 32'h0);
    for (int k = 0; k < 10; k++) begin
      clockCycle();
      checkOutput($sformatf("lone beat%0d", k),
                  expBeat(1'b1, 1'b1, 32'(256 + 4 * k), 32'(4096 + k), 32'h0));
      bus.m1_addr  = 32'(256 + 4 * (k + 1));
      bus.m1_wdata = 32'(4096 + k + 1);
      if (k == 9) bus.m1_req = 1'b0;
      clockCycle();
      checkOutput($sformatf("lone gap%0d", k), expIdle(1'b1, 1'b1));
    end
    clockCycle();
    checkOutput("lone idle", expIdle(1'b1, 1'b0));

    // Random traffic, including occasional resets, against the beat-level model.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    clockCycle();
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    $urandom);
      clockCycle();
      checkOutput($sformatf("rand%0d", n), modelOut());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
